// File: rtl/cpu_cfg_mailbox_pkg.sv
// Shared definitions for the N64 config mailbox: register addresses, STATUS and
// IRQ bit positions, and the CPU-bus handshake state type.
package cpu_cfg_mailbox_pkg;

  localparam int IRQ_SOURCES = 3;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_COMMAND  = 3'd1;
  localparam logic [2:0] ADDR_ARG0     = 3'd2;
  localparam logic [2:0] ADDR_ARG1     = 3'd3;
  localparam logic [2:0] ADDR_RESPONSE = 3'd4;
  localparam logic [2:0] ADDR_BOOT_ARG = 3'd5;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd6;

  localparam int ST_PENDING      = 0;
  localparam int ST_BUSY         = 1;
  localparam int ST_BOOT_PENDING = 2;
  localparam int ST_OVERRUN      = 3;
  localparam int ST_BOOTSTRAPPED = 4;

  localparam int IRQ_PENDING      = 0;
  localparam int IRQ_BOOT_PENDING = 1;
  localparam int IRQ_OVERRUN      = 2;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } e_state;

  function automatic logic [31:0] packStatus(
    input logic pending,
    input logic busy,
    input logic bootPending,
    input logic overrun,
    input logic bootstrapped
  );
    logic [31:0] word;
    word                  = '0;
    word[ST_PENDING]      = pending;
    word[ST_BUSY]         = busy;
    word[ST_BOOT_PENDING] = bootPending;
    word[ST_OVERRUN]      = overrun;
    word[ST_BOOTSTRAPPED] = bootstrapped;
    return word;
  endfunction

endpackage

// File: rtl/cpu_cfg_mailbox_if.sv
// Controller-CPU register window: single-cycle request strobe, registered
// acknowledge with read data, and a level interrupt back to the CPU.
interface cpu_cfg_mailbox_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        irq;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, irq
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, irq
  );

endinterface

// File: rtl/cpu_cfg_mailbox.sv
// Controller-CPU end of the N64 config command channel: latches N64 commands and
// boot arguments, and exposes them plus status/response through a register window.
module cpu_cfg_mailbox
  import cpu_cfg_mailbox_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_request,
  input  logic [7:0]             cfg_command,
  input  logic [31:0]            cfg_arg0,
  input  logic [31:0]            cfg_arg1,
  input  logic                   cfg_boot_write,
  output logic                   cfg_cpu_busy,
  output logic                   cfg_cpu_bootstrapped,
  output logic [31:0]            cfg_response,
  cpu_cfg_mailbox_if.slave       cpu
);

  e_state state_q;
  logic        ack_q;
  logic [31:0] rdata_q;

  logic busy_q, busy_d;
  logic pending_q, pending_d;
  logic bootPending_q, bootPending_d;
  logic overrun_q, overrun_d;
  logic bootstrapped_q, bootstrapped_d;
  logic irq_q;

  logic [7:0]             command_q, command_d;
  logic [31:0]            arg0_q, arg0_d;
  logic [31:0]            arg1_q, arg1_d;
  logic [31:0]            bootArg_q, bootArg_d;
  logic [31:0]            response_q, response_d;
  logic [IRQ_SOURCES-1:0] irqEn_q, irqEn_d;
  logic [IRQ_SOURCES-1:0] irqSrc;

  logic        access;
  logic        statusWr;
  logic        commandRd;
  logic        busyAfterDone;
  logic        acceptCmd;
  logic [31:0] readData;

  assign access    = cpu.cpu_req && (state_q == S_IDLE);
  assign statusWr  = access && cpu.cpu_we && (cpu.cpu_addr == ADDR_STATUS);
  assign commandRd = access && !cpu.cpu_we && (cpu.cpu_addr == ADDR_COMMAND);

  // DONE is applied before the request is judged, so a same-cycle request is accepted.
  assign busyAfterDone = busy_q && !(statusWr && cpu.cpu_wdata[ST_BUSY]);
  assign acceptCmd     = cfg_request && !busyAfterDone;

  always_comb begin
    readData = '0;
    case (cpu.cpu_addr)
      ADDR_STATUS:   readData = packStatus(pending_q, busy_q, bootPending_q,
                                           overrun_q, bootstrapped_q);
      ADDR_COMMAND:  readData = {24'd0, command_q};
      ADDR_ARG0:     readData = arg0_q;
      ADDR_ARG1:     readData = arg1_q;
      ADDR_RESPONSE: readData = response_q;
      ADDR_BOOT_ARG: readData = bootArg_q;
      ADDR_IRQ_EN:   readData = {{(32-IRQ_SOURCES){1'b0}}, irqEn_q};
      default:       readData = '0;
    endcase
  end

  always_comb begin
    busy_d         = busyAfterDone || acceptCmd;
    pending_d      = (pending_q && !commandRd) || acceptCmd;
    // Clearing by write-one loses to a set event arriving in the same cycle.
    bootPending_d  = (bootPending_q && !(statusWr && cpu.cpu_wdata[ST_BOOT_PENDING]))
                     || cfg_boot_write;
    overrun_d      = (overrun_q && !(statusWr && cpu.cpu_wdata[ST_OVERRUN]))
                     || (cfg_request && busyAfterDone);
    bootstrapped_d = statusWr ? cpu.cpu_wdata[ST_BOOTSTRAPPED] : bootstrapped_q;
    command_d      = acceptCmd ? cfg_command : command_q;
    arg0_d         = acceptCmd ? cfg_arg0 : arg0_q;
    arg1_d         = acceptCmd ? cfg_arg1 : arg1_q;
    bootArg_d      = cfg_boot_write ? cfg_arg0 : bootArg_q;
    response_d     = response_q;
    irqEn_d        = irqEn_q;
    if (access && cpu.cpu_we && (cpu.cpu_addr == ADDR_RESPONSE))
      response_d = cpu.cpu_wdata;
    if (access && cpu.cpu_we && (cpu.cpu_addr == ADDR_IRQ_EN))
      irqEn_d = cpu.cpu_wdata[IRQ_SOURCES-1:0];
  end

  // Handshake: an access in idle acks on the next cycle, then one dead cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu.cpu_req) begin
            ack_q   <= 1'b1;
            rdata_q <= cpu.cpu_we ? 32'd0 : readData;
            state_q <= S_ACK;
          end else begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
          end
        end
        S_ACK: begin
          ack_q   <= 1'b0;
          rdata_q <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          rdata_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign irqSrc[IRQ_PENDING]      = pending_q;
  assign irqSrc[IRQ_BOOT_PENDING] = bootPending_q;
  assign irqSrc[IRQ_OVERRUN]      = overrun_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q         <= 1'b0;
      pending_q      <= 1'b0;
      bootPending_q  <= 1'b0;
      overrun_q      <= 1'b0;
      bootstrapped_q <= 1'b0;
      command_q      <= '0;
      arg0_q         <= '0;
      arg1_q         <= '0;
      bootArg_q      <= '0;
      response_q     <= '0;
      irqEn_q        <= '0;
      irq_q          <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      pending_q      <= pending_d;
      bootPending_q  <= bootPending_d;
      overrun_q      <= overrun_d;
      bootstrapped_q <= bootstrapped_d;
      command_q      <= command_d;
      arg0_q         <= arg0_d;
      arg1_q         <= arg1_d;
      bootArg_q      <= bootArg_d;
      response_q     <= response_d;
      irqEn_q        <= irqEn_d;
      irq_q          <= |(irqEn_q & irqSrc);
    end
  end

  assign cpu.cpu_ack          = ack_q;
  assign cpu.cpu_rdata        = rdata_q;
  assign cpu.irq              = irq_q;
  assign cfg_cpu_busy         = busy_q;
  assign cfg_cpu_bootstrapped = bootstrapped_q;
  assign cfg_response         = response_q;

endmodule
